// File: rtl/multicycle_ctrl_v2_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// States, opcode/funct constants, ALU/PCSrc codes and trap causes.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF,
      S_ID,
      S_EXEC_R,
      S_EXEC_I,
      S_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_MEM_WB,
      S_BRANCH,
      S_JUMP,
      S_JAL,
      S_JR,
      S_TRAP
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [2:0] PC_ALU    = 3'b000;
   localparam logic [2:0] PC_JUMP   = 3'b001;
   localparam logic [2:0] PC_ALUOUT = 3'b010;
   localparam logic [2:0] PC_REGA   = 3'b011;
   localparam logic [2:0] PC_TRAP   = 3'b100;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_SHIMM = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_write;
      logic       mem_read;
      logic       ir_write;
      logic       reg_dst;
      logic       wr_reg_sel;
      logic       mem_to_reg;
      logic       wr_data_sel;
      logic       reg_write;
      logic       src_a;
      logic [1:0] src_b;
      logic [2:0] pc_src;
      logic [2:0] alu_op;
      logic       trap;
   } ctl_t;

   function automatic logic funct_is_alu(input logic [5:0] fn);
      return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      logic [2:0] op;
      op = ALU_ADD;
      unique case (1'b1)
         fn == FN_SUB: op = ALU_SUB;
         fn == FN_AND: op = ALU_AND;
         fn == FN_OR:  op = ALU_OR;
         fn == FN_SLT: op = ALU_SLT;
         default:      op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic [2:0] imm_alu(input logic [5:0] opc);
      logic [2:0] op;
      op = ALU_ADD;
      unique case (1'b1)
         opc == OP_ANDI: op = ALU_AND;
         opc == OP_ORI:  op = ALU_OR;
         opc == OP_SLTI: op = ALU_SLT;
         default:        op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic is_mem_state(input state_e s);
      return s inside {S_IF, S_MEM_RD, S_MEM_WR};
   endfunction

endpackage

// File: rtl/multicycle_ctrl_v2_if.sv
// Controller <-> datapath bundle: IR/flags/ready in, enables and selects out.
// master = controller, slave = datapath.
interface multicycle_ctrl_v2_if #(
   parameter int ALUOP_W = 3
);
   logic [31:0]        instruction;
   logic               zeroflag;
   logic               mem_ready;
   logic               PCWrite;
   logic               IorD;
   logic               MemWrite;
   logic               MemRead;
   logic               IRWrite;
   logic               RegDst;
   logic               WriteRegSel;
   logic               MemtoReg;
   logic               WriteDataSel;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [2:0]         PCSrc;
   logic [ALUOP_W-1:0] ALUoperation;
   logic               trap;
   logic [1:0]         trap_cause;

   modport master (
      input  instruction, zeroflag, mem_ready,
      output PCWrite, IorD, MemWrite, MemRead, IRWrite,
      output RegDst, WriteRegSel, MemtoReg, WriteDataSel,
      output RegWrite, ALUSrcA, ALUSrcB, PCSrc,
      output ALUoperation, trap, trap_cause
   );

   modport slave (
      output instruction, zeroflag, mem_ready,
      input  PCWrite, IorD, MemWrite, MemRead, IRWrite,
      input  RegDst, WriteRegSel, MemtoReg, WriteDataSel,
      input  RegWrite, ALUSrcA, ALUSrcB, PCSrc,
      input  ALUoperation, trap, trap_cause
   );
endinterface

// File: rtl/multicycle_ctrl_v2_mem_timer.sv
// Memory-wait watchdog for the controller (present only with MEM_TIMEOUT_EN).
// expired fires while waiting once the count has reached TIMEOUT_CYCLES-1.
`ifdef MEM_TIMEOUT_EN
module mc_mem_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waiting,
   output logic expired
);
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= 8'd0;
      end else if (clear) begin
         r_count <= 8'd0;
      end else if (waiting) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign expired = waiting && (r_count == LIMIT);
endmodule
`endif

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM with ready handshake and trap path.
// Define MEM_TIMEOUT_EN to bound memory waits with mc_mem_timer.
module multicycle_ctrl_v2
   import multicycle_ctrl_pkg::*;
#(
   parameter int ALUOP_W        = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                clk,
   input logic                rst,
   multicycle_ctrl_v2_if.master bus
);
   state_e     r_state;
   state_e     w_next;
   logic [1:0] r_cause;
   logic [1:0] w_next_cause;
   ctl_t       w_ctl;
   logic [5:0] w_op;
   logic [5:0] w_fn;
   logic       w_ready;
   logic       w_expired;
   logic       w_dec_r;
   logic       w_dec_jr;
   logic       w_dec_imm;
   logic       w_dec_mem;
   logic       w_dec_br;
   logic       w_dec_j;
   logic       w_dec_jal;
   logic       w_unused_bits;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..255");
   end

   assign w_op          = bus.instruction[31:26];
   assign w_fn          = bus.instruction[5:0];
   assign w_ready       = bus.mem_ready;
   assign w_unused_bits = ^bus.instruction[25:6];

   assign w_dec_r   = (w_op == OP_RTYPE) && funct_is_alu(w_fn);
   assign w_dec_jr  = (w_op == OP_RTYPE) && (w_fn == FN_JR);
   assign w_dec_imm = w_op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
   assign w_dec_mem = w_op inside {OP_LW, OP_SW};
   assign w_dec_br  = w_op inside {OP_BEQ, OP_BNE};
   assign w_dec_j   = (w_op == OP_J);
   assign w_dec_jal = (w_op == OP_JAL);

`ifdef MEM_TIMEOUT_EN
   logic w_waiting;
   logic w_clear;

   // Any state change restarts the count, which covers every memory-state entry.
   assign w_waiting = is_mem_state(r_state) && !w_ready;
   assign w_clear   = (w_next != r_state);

   mc_mem_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_clear),
      .waiting (w_waiting),
      .expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IF;
         r_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP) begin
            r_cause <= w_next_cause;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_next_cause = CAUSE_ILLEGAL;
      unique case (r_state)
         S_IF: begin
            if (w_ready) begin
               w_next = S_ID;
            end else if (w_expired) begin
               w_next       = S_TRAP;
               w_next_cause = CAUSE_TIMEOUT;
            end
         end
         S_ID: begin
            unique case (1'b1)
               w_dec_r:   w_next = S_EXEC_R;
               w_dec_jr:  w_next = S_JR;
               w_dec_imm: w_next = S_EXEC_I;
               w_dec_mem: w_next = S_MEM_ADDR;
               w_dec_br:  w_next = S_BRANCH;
               w_dec_j:   w_next = S_JUMP;
               w_dec_jal: w_next = S_JAL;
               default:   w_next = S_TRAP;
            endcase
         end
         S_EXEC_R, S_EXEC_I: w_next = S_WB;
         S_MEM_ADDR: begin
            w_next = (w_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            if (w_ready) begin
               w_next = S_MEM_WB;
            end else if (w_expired) begin
               w_next       = S_TRAP;
               w_next_cause = CAUSE_TIMEOUT;
            end
         end
         S_MEM_WR: begin
            if (w_ready) begin
               w_next = S_IF;
            end else if (w_expired) begin
               w_next       = S_TRAP;
               w_next_cause = CAUSE_TIMEOUT;
            end
         end
         S_WB, S_MEM_WB, S_BRANCH, S_JUMP,
         S_JAL, S_JR, S_TRAP: w_next = S_IF;
         default: w_next = S_IF;
      endcase
   end

   // Outputs are gated by rst so nothing asserts while reset is held.
   always_comb begin
      w_ctl = '0;
      if (rst) begin
         unique case (r_state)
            S_IF: begin
               w_ctl.mem_read = 1'b1;
               w_ctl.src_b    = SRCB_FOUR;
               w_ctl.alu_op   = ALU_ADD;
               w_ctl.pc_src   = PC_ALU;
               w_ctl.ir_write = w_ready;
               w_ctl.pc_write = w_ready;
            end
            S_ID: begin
               w_ctl.src_b  = SRCB_SHIMM;
               w_ctl.alu_op = ALU_ADD;
            end
            S_EXEC_R: begin
               w_ctl.src_a  = 1'b1;
               w_ctl.src_b  = SRCB_REGB;
               w_ctl.alu_op = funct_alu(w_fn);
            end
            S_EXEC_I: begin
               w_ctl.src_a  = 1'b1;
               w_ctl.src_b  = SRCB_IMM;
               w_ctl.alu_op = imm_alu(w_op);
            end
            S_WB: begin
               w_ctl.reg_write = 1'b1;
               w_ctl.reg_dst   = (w_op == OP_RTYPE);
            end
            S_MEM_ADDR: begin
               w_ctl.src_a  = 1'b1;
               w_ctl.src_b  = SRCB_IMM;
               w_ctl.alu_op = ALU_ADD;
            end
            S_MEM_RD: begin
               w_ctl.iord     = 1'b1;
               w_ctl.mem_read = 1'b1;
            end
            S_MEM_WR: begin
               w_ctl.iord      = 1'b1;
               w_ctl.mem_write = 1'b1;
            end
            S_MEM_WB: begin
               w_ctl.reg_write  = 1'b1;
               w_ctl.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
               w_ctl.src_a    = 1'b1;
               w_ctl.src_b    = SRCB_REGB;
               w_ctl.alu_op   = ALU_SUB;
               w_ctl.pc_src   = PC_ALUOUT;
               w_ctl.pc_write = (w_op == OP_BEQ) ? bus.zeroflag
                                                 : !bus.zeroflag;
            end
            S_JUMP: begin
               w_ctl.pc_src   = PC_JUMP;
               w_ctl.pc_write = 1'b1;
            end
            S_JAL: begin
               w_ctl.wr_reg_sel  = 1'b1;
               w_ctl.wr_data_sel = 1'b1;
               w_ctl.reg_write   = 1'b1;
               w_ctl.pc_src      = PC_JUMP;
               w_ctl.pc_write    = 1'b1;
            end
            S_JR: begin
               w_ctl.pc_src   = PC_REGA;
               w_ctl.pc_write = 1'b1;
            end
            S_TRAP: begin
               w_ctl.pc_src   = PC_TRAP;
               w_ctl.pc_write = 1'b1;
               w_ctl.trap     = 1'b1;
            end
            default: w_ctl = '0;
         endcase
      end
   end

   assign bus.PCWrite      = w_ctl.pc_write;
   assign bus.IorD         = w_ctl.iord;
   assign bus.MemWrite     = w_ctl.mem_write;
   assign bus.MemRead      = w_ctl.mem_read;
   assign bus.IRWrite      = w_ctl.ir_write;
   assign bus.RegDst       = w_ctl.reg_dst;
   assign bus.WriteRegSel  = w_ctl.wr_reg_sel;
   assign bus.MemtoReg     = w_ctl.mem_to_reg;
   assign bus.WriteDataSel = w_ctl.wr_data_sel;
   assign bus.RegWrite     = w_ctl.reg_write;
   assign bus.ALUSrcA      = w_ctl.src_a;
   assign bus.ALUSrcB      = w_ctl.src_b;
   assign bus.PCSrc        = w_ctl.pc_src;
   assign bus.ALUoperation = ALUOP_W'(w_ctl.alu_op);
   assign bus.trap         = w_ctl.trap;
   assign bus.trap_cause   = r_cause;
endmodule
